// File: rtl/mcyc_bus_seq.sv
// SM83 machine-cycle bus sequencer: T1..T4 phase, address/data latching,
// rd/wr strobes, read-data capture and the PC/SP increment/decrement unit.
module mcyc_bus_seq #(
  parameter int ADR_W  = 16,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stop,
  input  logic [1:0]        cmd,
  input  logic [1:0]        idu_op,
  input  logic [ADR_W-1:0]  adr_in,
  input  logic [DATA_W-1:0] wdata_in,
  input  logic [DATA_W-1:0] din,
  output logic [3:0]        t_state,
  output logic [ADR_W-1:0]  adr,
  output logic              rd,
  output logic              wr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_en,
  output logic [DATA_W-1:0] data_lat,
  output logic [ADR_W-1:0]  idu_out,
  output logic              idu_we
);

  typedef enum logic [3:0] {
    T1 = 4'b0001,
    T2 = 4'b0010,
    T3 = 4'b0100,
    T4 = 4'b1000
  } phase_e;

  typedef enum logic [1:0] {
    CMD_NONE  = 2'b00,
    CMD_READ  = 2'b01,
    CMD_WRITE = 2'b10
  } cmd_e;

  localparam logic [1:0] IDU_HOLD = 2'b00;
  localparam logic [1:0] IDU_INC  = 2'b01;
  localparam logic [1:0] IDU_DEC  = 2'b10;
  localparam logic [1:0] IDU_ZERO = 2'b11;

  phase_e            phase_q, phase_d;
  cmd_e              cmd_q, cmd_d;
  logic [1:0]        op_q, op_d;
  logic [ADR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0] wdat_q, wdat_d;
  logic [DATA_W-1:0] lat_q, lat_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= T4;
      cmd_q   <= CMD_NONE;
      op_q    <= IDU_HOLD;
      adr_q   <= '0;
      wdat_q  <= '0;
      lat_q   <= '0;
    end else begin
      phase_q <= phase_d;
      cmd_q   <= cmd_d;
      op_q    <= op_d;
      adr_q   <= adr_d;
      wdat_q  <= wdat_d;
      lat_q   <= lat_d;
    end
  end

  always_comb begin
    phase_d = phase_q;
    cmd_d   = cmd_q;
    op_d    = op_q;
    adr_d   = adr_q;
    wdat_d  = wdat_q;
    lat_d   = lat_q;
    unique case (phase_q)
      T1: phase_d = T2;
      T2: phase_d = T3;
      T3: begin
        phase_d = T4;
        if (cmd_q == CMD_READ) lat_d = din;
      end
      T4: begin
        if (stop) begin
          // Frozen: keep the bus quiet and suppress any writeback.
          phase_d = T4;
          cmd_d   = CMD_NONE;
          op_d    = IDU_HOLD;
        end else begin
          phase_d = T1;
          op_d    = idu_op;
          adr_d   = adr_in;
          wdat_d  = wdata_in;
          unique case (cmd)
            2'b01:   cmd_d = CMD_READ;
            2'b10:   cmd_d = CMD_WRITE;
            default: cmd_d = CMD_NONE;
          endcase
        end
      end
      default: phase_d = T4;
    endcase
  end

  always_comb begin
    idu_out = adr_q;
    unique case (op_q)
      IDU_INC:  idu_out = adr_q + ADR_W'(1);
      IDU_DEC:  idu_out = adr_q - ADR_W'(1);
      IDU_ZERO: idu_out = '0;
      default:  idu_out = adr_q;
    endcase
  end

  assign t_state  = phase_q;
  assign adr      = adr_q;
  assign dout     = wdat_q;
  assign data_lat = lat_q;
  assign rd       = (cmd_q == CMD_READ) && !phase_q[3];
  assign wr       = (cmd_q == CMD_WRITE) && (phase_q[1] || phase_q[2]);
  assign dout_en  = (cmd_q == CMD_WRITE) && !phase_q[0];
  assign idu_we   = phase_q[3] && (op_q != IDU_HOLD) && !stop;

endmodule
